// File: rtl/isqrt_pkg.sv
// Shared widths, FSM state encoding and cycle-count helper for the iterative isqrt.
package isqrt_pkg;

   localparam int X_W   = 32;
   localparam int Y_W   = 16;
   localparam int REM_W = 18;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int n_cycles(input int k);
      return 16 / k;
   endfunction

endpackage

// File: rtl/isqrt_step.sv
// One digit-by-digit square-root iteration: brings in two operand bits, resolves one root bit.
// Purely combinational; no latency and no flow control.
module isqrt_step
   import isqrt_pkg::*;
(
   input  logic [REM_W-1:0] rem,
   input  logic [Y_W-1:0]   root,
   input  logic [1:0]       bits,
   output logic [REM_W-1:0] rem_next,
   output logic [Y_W-1:0]   root_next
);

   logic [REM_W-1:0] shifted;
   logic [REM_W-1:0] trial;

   // rem never exceeds 2*root, so the bits shifted out of the top are always zero.
   always_comb begin
      shifted = {rem[REM_W-3:0], bits};
      trial   = {root, 2'b01};
      if (shifted >= trial) begin
         rem_next  = shifted - trial;
         root_next = {root[Y_W-2:0], 1'b1};
      end else begin
         rem_next  = shifted;
         root_next = {root[Y_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/isqrt_iter_fsm.sv
// Iterative y = floor(sqrt(x)), ITER_PER_CYCLE root bits per clock; y_vld N+1 cycles after accept.
// No backpressure: x_vld is dropped while busy, a new operand may be taken in the DONE cycle.
module isqrt_iter_fsm
   import isqrt_pkg::*;
#(
   parameter int ITER_PER_CYCLE = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           x_vld,
   input  logic [X_W-1:0] x,
   output logic           y_vld,
   output logic [Y_W-1:0] y,
   output logic           busy
);

   localparam int N = n_cycles(ITER_PER_CYCLE);

   generate
      if (!(ITER_PER_CYCLE == 1 || ITER_PER_CYCLE == 2 || ITER_PER_CYCLE == 4 ||
            ITER_PER_CYCLE == 8 || ITER_PER_CYCLE == 16)) begin : g_bad_k
         $error("isqrt_iter_fsm: ITER_PER_CYCLE must be 1, 2, 4, 8 or 16");
      end
   endgenerate

   state_t           state;
   logic [X_W-1:0]   opnd;
   logic [REM_W-1:0] rem;
   logic [Y_W-1:0]   root;
   logic [3:0]       cnt;

   logic [REM_W-1:0] rem_c  [ITER_PER_CYCLE+1];
   logic [Y_W-1:0]   root_c [ITER_PER_CYCLE+1];

   assign rem_c[0]  = rem;
   assign root_c[0] = root;

   // Step i consumes the i-th bit pair from the top of the operand register.
   genvar i;
   generate
      for (i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
         isqrt_step u_step (
            .rem       (rem_c[i]),
            .root      (root_c[i]),
            .bits      (opnd[X_W-1-2*i -: 2]),
            .rem_next  (rem_c[i+1]),
            .root_next (root_c[i+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         y_vld <= 1'b0;
         y     <= '0;
         busy  <= 1'b0;
         opnd  <= '0;
         rem   <= '0;
         root  <= '0;
         cnt   <= '0;
      end else begin
         y_vld <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (x_vld) begin
                  opnd  <= x;
                  rem   <= '0;
                  root  <= '0;
                  cnt   <= 4'(N - 1);
                  busy  <= 1'b1;
                  state <= CALC;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            CALC: begin
               opnd <= opnd << (2 * ITER_PER_CYCLE);
               rem  <= rem_c[ITER_PER_CYCLE];
               root <= root_c[ITER_PER_CYCLE];
               cnt  <= cnt - 4'd1;
               if (cnt == 4'd0) begin
                  y     <= root_c[ITER_PER_CYCLE];
                  y_vld <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Bench for isqrt_iter_fsm: one DUT per legal ITER_PER_CYCLE, scoreboard checks value and exact cycle.
module tb_isqrt_iter_fsm;

   localparam int KS [5] = '{1, 2, 4, 8, 16};

   typedef struct {
      int          d;
      logic [31:0] x;
      logic [15:0] y;
      int          due;
   } exp_t;

   typedef struct {
      logic [31:0] x;
      logic [15:0] y;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  xv  = '0;
   logic [31:0] xb  = '0;
   logic [4:0]  yv;
   logic [15:0] yo [5];
   logic [4:0]  bs;

   int   cyc  = 0;
   int   errs = 0;
   int   nchk = 0;
   exp_t sb [$];
   vec_t tbl [11];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   genvar g;
   generate
      for (g = 0; g < 5; g++) begin : g_dut
         isqrt_iter_fsm #(.ITER_PER_CYCLE(KS[g])) u_dut (
            .clk   (clk),
            .rst   (rst),
            .x_vld (xv[g]),
            .x     (xb),
            .y_vld (yv[g]),
            .y     (yo[g]),
            .busy  (bs[g])
         );
      end
   endgenerate

   function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
      logic [15:0] r;
      logic [15:0] t;
      logic [31:0] p;
      r = '0;
      for (int b = 15; b >= 0; b--) begin
         t = r | 16'(1 << b);
         p = 32'(t) * 32'(t);
         if (p <= v) r = t;
      end
      return r;
   endfunction

   function automatic int nk(input int d);
      return 16 / KS[d];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      nchk++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s cycle=%0d got=%h required=%h", name, cyc, act, req);
      end
   endtask

   // Holds x_vld for exactly one cycle; returns one cycle later.
   task automatic send(input int d, input logic [31:0] v, input logic [15:0] ey, input bit track);
      xb    = v;
      xv[d] = 1'b1;
      if (track) sb.push_back('{d, v, ey, cyc + nk(d) + 1});
      tick();
      xv[d] = 1'b0;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 5; i++) begin
            if (yv[i]) begin
               nchk++;
               if (sb.size() == 0 || sb[0].d != i) begin
                  errs++;
                  $display("FAIL unexpected_y_vld K=%0d cycle=%0d y=%h required=no result",
                           KS[i], cyc, yo[i]);
               end else begin
                  e = sb.pop_front();
                  if (yo[i] !== e.y || cyc != e.due) begin
                     errs++;
                     $display("FAIL result K=%0d x=%h got y=%h at cycle %0d required y=%h at cycle %0d",
                              KS[i], e.x, yo[i], cyc, e.y, e.due);
                  end
               end
            end
         end
         if (sb.size() > 0 && cyc > sb[0].due) begin
            nchk++;
            errs++;
            e = sb.pop_front();
            $display("FAIL missing_y_vld K=%0d x=%h got=none required y=%h at cycle %0d",
                     KS[e.d], e.x, e.y, e.due);
         end
      end
   endtask

   task automatic run_rand(input int d, input int count);
      logic [31:0] v;
      int unsigned n;
      for (int i = 0; i < count; i++) begin
         if (i == 0)      v = 32'd0;
         else if (i == 1) v = 32'd1;
         else if (i == 2) v = 32'hFFFF_FFFF;
         else begin
            case ($urandom_range(0, 3))
               0: v = $urandom;
               1: begin n = $urandom_range(0, 65535); v = 32'(n * n); end
               2: begin n = $urandom_range(1, 65535); v = 32'(n * n - 1); end
               default: v = $urandom_range(0, 1000);
            endcase
         end
         send(d, v, ref_sqrt(v), 1'b1);
         repeat (nk(d)) tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycle=%0d got=still running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{32'd0,          16'd0};
      tbl[1]  = '{32'd1,          16'd1};
      tbl[2]  = '{32'd100,        16'd10};
      tbl[3]  = '{32'd99,         16'd9};
      tbl[4]  = '{32'hFFFF_FFFF,  16'hFFFF};
      tbl[5]  = '{32'hFFFE_0001,  16'hFFFF};
      tbl[6]  = '{32'hFFFE_0000,  16'hFFFE};
      tbl[7]  = '{32'd2,          16'd1};
      tbl[8]  = '{32'd15,         16'd3};
      tbl[9]  = '{32'd16,         16'd4};
      tbl[10] = '{32'd65536,      16'd256};

      fork
         monitor();
      join_none

      rst = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk("reset_y_vld", 32'(yv[i]), 32'd0);
         chk("reset_y", 32'(yo[i]), 32'd0);
         chk("reset_busy", 32'(bs[i]), 32'd0);
      end
      tick();
      rst = 1'b0;
      tick();

      // K=1 table, issued back-to-back in each DONE cycle
      for (int i = 0; i < 11; i++) begin
         send(0, tbl[i].x, tbl[i].y, 1'b1);
         repeat (nk(0)) tick();
      end
      repeat (5) tick();

      // operand offered mid-CALC must vanish
      send(0, 32'd16, 16'd4, 1'b1);
      repeat (4) tick();
      send(0, 32'd81, 16'd9, 1'b0);
      repeat (40) tick();

      // accept in the DONE cycle; busy low only in cycles 0, 17, 34 (and idle after)
      for (int c = 0; c < 36; c++) begin
         xv[0] = (c == 0 || c == 17);
         xb    = (c == 0) ? 32'd49 : 32'd64;
         if (xv[0]) sb.push_back('{0, xb, (c == 0) ? 16'd7 : 16'd8, cyc + 17});
         @(negedge clk);
         chk($sformatf("busy_c%0d", c), 32'(bs[0]),
             (c == 0 || c == 17 || c >= 34) ? 32'd0 : 32'd1);
         tick();
      end
      xv[0] = 1'b0;
      repeat (3) tick();

      // reset in cycle 8 aborts the operation
      send(0, 32'd1000000, 16'd1000, 1'b0);
      repeat (7) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 9; c < 25; c++) begin
         @(negedge clk);
         chk("abort_busy", 32'(bs[0]), 32'd0);
         chk("abort_y", 32'(yo[0]), 32'd0);
         tick();
      end
      send(0, 32'd4, 16'd2, 1'b1);
      repeat (20) tick();

      run_rand(2, 10000);
      run_rand(1, 500);
      run_rand(3, 1000);
      run_rand(4, 1000);

      for (int t = 0; t < 40 && sb.size() > 0; t++) tick();
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end

endmodule
